// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with in-order {pc, instr} queue
module fetch_unit #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          IMEM_BYTES  = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fetch_oob
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    logic [63:0]   pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [63:0]   q_pc    [QUEUE_DEPTH];
    logic [31:0]   q_instr [QUEUE_DEPTH];
    logic          deq;
    logic          enq;

    assign imem_addr = pc;

    // 65-bit compare so a PC near the top of the address space cannot wrap into range
    always_comb begin
        fetch_oob = ({1'b0, pc} + 65'd3) >= 65'(IMEM_BYTES);
        out_valid = (count != '0);
        deq       = out_valid & out_ready;
        enq       = !redirect_valid & !fetch_oob & ((count < CW'(QUEUE_DEPTH)) | deq);
        out_instr = out_valid ? q_instr[head] : 32'd0;
        out_pc    = out_valid ? q_pc[head]    : 64'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc[i]    <= 64'd0;
                q_instr[i] <= 32'd0;
            end
        end else if (redirect_valid) begin
            pc    <= redirect_pc & ~64'd3;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (deq) begin
                head <= head + PW'(1);
            end
            if (enq) begin
                q_pc[tail]    <= pc;
                q_instr[tail] <= imem_instr;
                tail          <= tail + PW'(1);
                pc            <= pc + 64'd4;
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end
endmodule
